// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, control bundle and counter widths.
package pipe_ctrl_pkg;

    localparam int STALL_W = 32;
    localparam int DIV_CYCLES_DEF = 33;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_stall;
        logic if_id_flush;
        logic id_exe_stall;
        logic id_exe_flush;
        logic exe_mem_flush;
        logic div_start;
        logic div_busy;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        c.pc_en = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_div_hold();
        ctrl_t c;
        c = '0;
        c.if_id_stall = 1'b1;
        c.id_exe_stall = 1'b1;
        c.exe_mem_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; increments while inc is high
// and sticks at all-ones.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = STALL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: add one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use,
// taken-branch redirect and multi-cycle divide occupancy.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exe_div_valid,
    input  logic               exe_is_load,
    input  logic [4:0]         exe_rd,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               exe_branch_taken,
    output logic               pc_en,
    output logic               if_id_stall,
    output logic               if_id_flush,
    output logic               id_exe_stall,
    output logic               id_exe_flush,
    output logic               exe_mem_flush,
    output logic               div_start,
    output logic               div_busy,
    output logic [STALL_W-1:0] stall_cycles
);

    // cnt runs from DIV_CYCLES-2 down to 0, so clog2 bits suffice.
    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    hz_state_e        state_d;
    hz_state_e        state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl;
    logic             load_use;
    logic             rs1_hit;
    logic             rs2_hit;

    // Dependency of the ID instruction on a load sitting in EXE.
    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == exe_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == exe_rd);
        load_use = exe_is_load && (exe_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Next state, divide countdown and pipeline controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = ctrl_idle();
        unique case (state_q)
            RUN: begin
                if (exe_div_valid) begin
                    ctrl           = ctrl_div_hold();
                    ctrl.div_start = 1'b1;
                    cnt_d          = CNT_LOAD;
                    state_d        = DIV_BUSY;
                end else if (exe_branch_taken) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_exe_flush = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_en        = 1'b0;
                    ctrl.if_id_stall  = 1'b1;
                    ctrl.id_exe_flush = 1'b1;
                end
            end
            DIV_BUSY: begin
                ctrl          = ctrl_div_hold();
                ctrl.div_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                // Same divide still in EXE: exe_div_valid ignored.
                state_d = RUN;
                if (exe_branch_taken) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_exe_flush = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and divide countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_stall   = ctrl.if_id_stall;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_exe_stall  = ctrl.id_exe_stall;
    assign id_exe_flush  = ctrl.id_exe_flush;
    assign exe_mem_flush = ctrl.exe_mem_flush;
    assign div_start     = ctrl.div_start;
    assign div_busy      = ctrl.div_busy;

    sat_counter #(
        .W(STALL_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (~ctrl.pc_en),
        .count(stall_cycles)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32IMC pipeline. Every cycle it drives the enable, stall and flush controls of the PC, the IF/ID register, the ID/EXE register and the EXE/MEM register. It handles three cases: load-use hazards, taken-branch redirects, and multi-cycle divide occupancy of EXE. It also owns the divider start pulse, the divider busy countdown and a saturating stall-cycle performance counter.

## Interface
- `DIV_CYCLES`, default 33: divider latency in cycles from `div_start` to a valid result. Legal range is ≥2.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `exe_div_valid` in 1: the instruction in EXE is a DIV/DIVU/REM/REMU.
- `exe_is_load` in 1: the instruction in EXE reads data memory.
- `exe_rd` in 5: destination register of the instruction in EXE.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction actually reads that source.
- `exe_branch_taken` in 1: the branch or jump in EXE redirects the PC.
- `pc_en` out 1: the PC register may update.
- `if_id_stall`, `if_id_flush` out 1 each: hold / clear the IF/ID register.
- `id_exe_stall`, `id_exe_flush` out 1 each: hold / clear the ID/EXE register.
- `exe_mem_flush` out 1: insert a bubble into EXE/MEM.
- `div_start` out 1: single-cycle start pulse to the divider.
- `div_busy` out 1: a divide is in progress (state DIV_BUSY).
- `stall_cycles` out 32: count of cycles with `pc_en`=0, saturating at 0xFFFFFFFF.

## Operation
- FSM states:
  - RUN: normal issue.
  - DIV_BUSY: EXE is frozen on a divide.
  - DIV_DONE: the divide result is consumed and the pipeline advances.
- RUN with `exe_div_valid`=1:
  - `div_start`=1.
  - Stall the PC, IF/ID and ID/EXE (`pc_en`=0, both stalls =1).
  - `exe_mem_flush`=1.
  - Load `cnt` with DIV_CYCLES−2 and go to DIV_BUSY.
- DIV_BUSY:
  - Same stall and flush outputs as the start cycle, with `div_start`=0 and `div_busy`=1.
  - `cnt` decrements each cycle.
  - When `cnt`==0, go to DIV_DONE.
- DIV_DONE:
  - No stalls and no flushes; the pipeline advances.
  - `exe_div_valid` is ignored, because it is still the same instruction.
  - Always returns to RUN.
- Load-use hazard (RUN only): all of the following hold:
  - `exe_is_load`=1 and `exe_rd`≠0;
  - (`id_use_rs1` and `id_rs1`==`exe_rd`) or (`id_use_rs2` and `id_rs2`==`exe_rd`).
  - Response: `pc_en`=0, `if_id_stall`=1, `id_exe_flush`=1 (bubble). Lasts one cycle, with no state change.
- Taken branch (RUN or DIV_DONE): `if_id_flush`=1 and `id_exe_flush`=1; `pc_en`=1 so the PC loads the target.
- Priority: `rst` > divide start/busy > branch flush > load-use stall.
- `exe_branch_taken` or `exe_is_load` together with `exe_div_valid` is illegal; the bench asserts against it.
- Outputs are combinational from state plus inputs. `cnt`, state and `stall_cycles` are registered.
- `stall_cycles` increments on every cycle with `pc_en`=0 and holds at all-ones.

## Timing
- Reset, asynchronous and immediate:
  - State = RUN, `cnt`=0, `stall_cycles`=0.
  - Outputs: `pc_en`=1, every stall and flush output =0, `div_start`=0, `div_busy`=0, unless inputs demand otherwise.
- Divide occupancy of EXE is exactly DIV_CYCLES+1 cycles: 1 start cycle, DIV_CYCLES−1 DIV_BUSY cycles, 1 DIV_DONE cycle. The PC is frozen for DIV_CYCLES of them.
- DIV_CYCLES=2: DIV_BUSY lasts one cycle (`cnt` loads 0).
- Back-to-back divides: DIV_DONE → RUN, and the next divide starts in that RUN cycle with no extra bubble.
- Load-use costs exactly one stall cycle; the dependent instruction reaches EXE on the second cycle.
- `rst` asserted during DIV_BUSY aborts the divide: the FSM returns to RUN immediately and `div_busy` drops in the same cycle.
- Branch flush has zero-cycle latency: flushes assert in the same cycle `exe_branch_taken` is high.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - State enum {RUN, DIV_BUSY, DIV_DONE}.
  - Constant for the `stall_cycles` width (32).
  - Constant for the default DIV_CYCLES.
- Optional sub-module `sat_counter` holds the saturating `stall_cycles` counter, with width as a parameter. All other logic is single-module.

## Test plan
- Reset with DIV_CYCLES=33 → `pc_en`=1, all flush/stall=0, `stall_cycles`=0.
- `exe_div_valid`=1 held, DIV_CYCLES=33 → `div_start` high for 1 cycle; `pc_en`=0 for 33 cycles; `div_busy` high for 32; DIV_DONE on cycle 34; `stall_cycles`=33.
- Load in EXE with `exe_rd`=5, ID `id_rs2`=5 and `id_use_rs2`=1 → one cycle with `pc_en`=0, `if_id_stall`=1, `id_exe_flush`=1. Same stimulus with `exe_rd`=0 → no stall.
- `exe_branch_taken`=1 together with a load-use match → `if_id_flush`=1, `id_exe_flush`=1, `pc_en`=1, `if_id_stall`=0.
- Two consecutive divides, DIV_CYCLES=4 → second `div_start` occurs 5 cycles after the first, with no dead cycle.
- `rst` pulsed at DIV_BUSY cycle 10 → RUN immediately; `div_busy`=0, `cnt`=0 and `stall_cycles`=0 during reset.
